// File: rtl/sprite_sched_pkg.sv
// Shared types, field positions and constants for the sprite frame scheduler.
package sprite_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMMIT,
      S_ANIM
   } sched_state_t;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       vis;
      logic       ovr;
      logic [1:0] spr;
   } sprite_word_t;

   localparam logic [1:0] SEL_MARIO  = 2'd0;
   localparam logic [1:0] SEL_BARRIL = 2'd1;
   localparam logic [1:0] SEL_DK     = 2'd2;

   localparam logic [9:0] V_COMMIT = 10'd480;
   localparam logic [9:0] H_MAX    = 10'd639;
   localparam logic [9:0] V_MAX    = 10'd479;

   localparam int ANIM_FRAMES_DEF = 8;

   // Bit positions of the fields inside a CPU position word.
   localparam int H_LSB   = 0;
   localparam int V_LSB   = 16;
   localparam int VIS_BIT = 28;
   localparam int SPR_LSB = 29;
   localparam int OVR_BIT = 31;

   localparam logic [9:0] MARIO_H0  = 10'd155;
   localparam logic [9:0] MARIO_V0  = 10'd427;
   localparam logic [9:0] BARRIL_H0 = 10'd215;
   localparam logic [9:0] BARRIL_V0 = 10'd236;
   localparam logic [9:0] DK_H0     = 10'd160;
   localparam logic [9:0] DK_V0     = 10'd220;

   localparam logic [1:0] SPR_RESET = 2'b01;

   function automatic logic [9:0] clamp10(input logic [9:0] val, input logic [9:0] maxVal);
      return (val > maxVal) ? maxVal : val;
   endfunction

endpackage

// File: rtl/sprite_frame_scheduler_entry.sv
// One sprite's shadow word, dirty flag and live word; writes are clamped on entry
// and only reach the live word when the scheduler commits at vblank.
module sprite_shadow_entry
   import sprite_sched_pkg::*;
#(
   parameter logic [9:0] H0 = 10'd0,
   parameter logic [9:0] V0 = 10'd0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en_i,
   input  logic [31:0] wr_data_i,
   input  logic        commit_i,
   output logic [9:0]  h_o,
   output logic [9:0]  v_o,
   output logic        vis_o,
   output logic        ovr_o,
   output logic [1:0]  spr_o
);

   localparam sprite_word_t RESET_WORD = '{h: H0, v: V0, vis: 1'b1, ovr: 1'b0, spr: SPR_RESET};

   sprite_word_t shadow_q, shadow_d;
   sprite_word_t live_q, live_d;
   sprite_word_t wr_word;
   logic         dirty_q, dirty_d;
   logic         unused_bits;

   assign unused_bits = ^{wr_data_i[15:10], wr_data_i[27:26]};

   always_comb begin
      wr_word.h   = clamp10(wr_data_i[H_LSB +: 10], H_MAX);
      wr_word.v   = clamp10(wr_data_i[V_LSB +: 10], V_MAX);
      wr_word.vis = wr_data_i[VIS_BIT];
      wr_word.ovr = wr_data_i[OVR_BIT];
      wr_word.spr = wr_data_i[SPR_LSB +: 2];

      shadow_d = shadow_q;
      live_d   = live_q;
      dirty_d  = dirty_q;
      if (commit_i && dirty_q) begin
         live_d  = shadow_q;
         dirty_d = 1'b0;
      end
      if (wr_en_i) begin
         shadow_d = wr_word;
         dirty_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= RESET_WORD;
         live_q   <= RESET_WORD;
         dirty_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         live_q   <= live_d;
         dirty_q  <= dirty_d;
      end
   end

   assign h_o   = live_q.h;
   assign v_o   = live_q.v;
   assign vis_o = live_q.vis;
   assign ovr_o = live_q.ovr;
   assign spr_o = live_q.spr;

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Frame-synchronous sprite position scheduler: CPU writes are buffered per sprite and
// committed once per frame on vblank entry, followed by one animation-advance cycle.
module sprite_frame_scheduler
   import sprite_sched_pkg::*;
#(
   parameter int ANIM_FRAMES = ANIM_FRAMES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        wr_valid,
   input  logic [1:0]  wr_sel,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic [9:0]  mario_h,
   output logic [9:0]  mario_v,
   output logic [9:0]  barril_h,
   output logic [9:0]  barril_v,
   output logic [9:0]  dk_h,
   output logic [9:0]  dk_v,
   output logic [1:0]  sprite_m,
   output logic [1:0]  sprite_dk,
   output logic        display_barril,
   output logic        frame_tick
);

   localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_FRAMES - 1);

   sched_state_t      state_q;
   logic [9:0]        vcount_q;
   logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;
   logic              anim_q, anim_d, anim_wrap;
   logic              wr_ready_q, frame_tick_q;
   logic [1:0]        sprite_m_q, sprite_dk_q;
   logic              frame_edge, accept, commit;
   logic              mario_ovr, dk_ovr;
   logic [1:0]        mario_spr, dk_spr;
   logic              unused_hcount, unused_mario_vis, unused_dk_vis, unused_barril_ovr;
   logic [1:0]        unused_barril_spr;

   assign unused_hcount = ^hcount;

   // vcount can sit on the commit line for many clocks; only its first appearance counts.
   assign frame_edge = (vcount == V_COMMIT) && (vcount_q != V_COMMIT);
   assign accept     = wr_valid && wr_ready_q && (state_q == S_IDLE);
   assign commit     = (state_q == S_COMMIT);
   assign anim_wrap  = (anim_cnt_q == ANIM_LAST);
   assign anim_cnt_d = anim_wrap ? '0 : anim_cnt_q + ANIM_W'(1);
   assign anim_d     = anim_q ^ anim_wrap;

   sprite_shadow_entry #(.H0(MARIO_H0), .V0(MARIO_V0)) u_mario (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (accept && (wr_sel == SEL_MARIO)),
      .wr_data_i (wr_data),
      .commit_i  (commit),
      .h_o       (mario_h),
      .v_o       (mario_v),
      .vis_o     (unused_mario_vis),
      .ovr_o     (mario_ovr),
      .spr_o     (mario_spr)
   );

   sprite_shadow_entry #(.H0(BARRIL_H0), .V0(BARRIL_V0)) u_barril (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (accept && (wr_sel == SEL_BARRIL)),
      .wr_data_i (wr_data),
      .commit_i  (commit),
      .h_o       (barril_h),
      .v_o       (barril_v),
      .vis_o     (display_barril),
      .ovr_o     (unused_barril_ovr),
      .spr_o     (unused_barril_spr)
   );

   sprite_shadow_entry #(.H0(DK_H0), .V0(DK_V0)) u_dk (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (accept && (wr_sel == SEL_DK)),
      .wr_data_i (wr_data),
      .commit_i  (commit),
      .h_o       (dk_h),
      .v_o       (dk_v),
      .vis_o     (unused_dk_vis),
      .ovr_o     (dk_ovr),
      .spr_o     (dk_spr)
   );

   // Sprite selects are refreshed in ANIM, after COMMIT has settled the live override bits.
   always_ff @(posedge clk) begin
      vcount_q <= vcount;
      if (reset) begin
         state_q      <= S_IDLE;
         anim_cnt_q   <= '0;
         anim_q       <= 1'b0;
         wr_ready_q   <= 1'b0;
         frame_tick_q <= 1'b0;
         sprite_m_q   <= SPR_RESET;
         sprite_dk_q  <= SPR_RESET;
      end else begin
         frame_tick_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (frame_edge) begin
                  state_q    <= S_COMMIT;
                  wr_ready_q <= 1'b0;
               end else begin
                  wr_ready_q <= 1'b1;
               end
            end
            S_COMMIT: begin
               state_q      <= S_ANIM;
               frame_tick_q <= 1'b1;
            end
            S_ANIM: begin
               state_q     <= S_IDLE;
               wr_ready_q  <= 1'b1;
               anim_cnt_q  <= anim_cnt_d;
               anim_q      <= anim_d;
               sprite_m_q  <= mario_ovr ? mario_spr : {1'b0, ~anim_d};
               sprite_dk_q <= dk_ovr ? dk_spr : {1'b0, ~anim_d};
            end
            default: begin
               state_q    <= S_IDLE;
               wr_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ready   = wr_ready_q;
   assign frame_tick = frame_tick_q;
   assign sprite_m   = sprite_m_q;
   assign sprite_dk  = sprite_dk_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Bench for sprite_frame_scheduler: directed scenarios and randomized frames checked
// against a per-sprite shadow/live reference model with frame-count based animation.
`timescale 1ns/1ps
module tb_sprite_frame_scheduler;

   localparam int ANIM_FRAMES = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hcount, vcount;
   logic        wr_valid;
   logic [1:0]  wr_sel;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic [9:0]  mario_h, mario_v, barril_h, barril_v, dk_h, dk_v;
   logic [1:0]  sprite_m, sprite_dk;
   logic        display_barril, frame_tick;

   typedef struct {
      int h;
      int v;
      int vis;
      int ovr;
      int spr;
   } mword_t;

   mword_t mShadow [3];
   mword_t mLive [3];
   bit     mDirty [3];
   int     mFrames;
   int     checks = 0;
   int     failures = 0;

   always #5 clk = ~clk;

   sprite_frame_scheduler #(.ANIM_FRAMES(ANIM_FRAMES)) dut (
      .clk            (clk),
      .reset          (reset),
      .hcount         (hcount),
      .vcount         (vcount),
      .wr_valid       (wr_valid),
      .wr_sel         (wr_sel),
      .wr_data        (wr_data),
      .wr_ready       (wr_ready),
      .mario_h        (mario_h),
      .mario_v        (mario_v),
      .barril_h       (barril_h),
      .barril_v       (barril_v),
      .dk_h           (dk_h),
      .dk_v           (dk_v),
      .sprite_m       (sprite_m),
      .sprite_dk      (sprite_dk),
      .display_barril (display_barril),
      .frame_tick     (frame_tick)
   );

   function automatic mword_t defaultWord(input int idx);
      mword_t w;
      w.vis = 1;
      w.ovr = 0;
      w.spr = 1;
      case (idx)
         0:       begin w.h = 155; w.v = 427; end
         1:       begin w.h = 215; w.v = 236; end
         default: begin w.h = 160; w.v = 220; end
      endcase
      return w;
   endfunction

   function automatic mword_t decodeWord(input logic [31:0] d);
      mword_t w;
      w.h   = (int'(d[9:0]) > 639) ? 639 : int'(d[9:0]);
      w.v   = (int'(d[25:16]) > 479) ? 479 : int'(d[25:16]);
      w.vis = int'(d[28]);
      w.ovr = int'(d[31]);
      w.spr = int'(d[30:29]);
      return w;
   endfunction

   function automatic logic [31:0] mkWord(input int h, input int v, input int vis, input int spr, input int ovr);
      logic [31:0] w;
      w        = '0;
      w[9:0]   = h[9:0];
      w[25:16] = v[9:0];
      w[28]    = vis[0];
      w[30:29] = spr[1:0];
      w[31]    = ovr[0];
      return w;
   endfunction

   function automatic int expSprite(input int idx);
      int animBit;
      animBit = (mFrames / ANIM_FRAMES) % 2;
      if (mLive[idx].ovr != 0) return mLive[idx].spr;
      return (animBit != 0) ? 0 : 1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mShadow[i] = defaultWord(i);
         mLive[i]   = defaultWord(i);
         mDirty[i]  = 1'b0;
      end
      mFrames = 0;
   endtask

   task automatic modelWrite(input logic [1:0] sel, input logic [31:0] data);
      if (sel != 2'd3) begin
         mShadow[sel] = decodeWord(data);
         mDirty[sel]  = 1'b1;
      end
   endtask

   task automatic modelCommit();
      for (int i = 0; i < 3; i++) begin
         if (mDirty[i]) begin
            mLive[i]  = mShadow[i];
            mDirty[i] = 1'b0;
         end
      end
      mFrames++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkPositions(input string tag);
      checkOutput({tag, "_mario_h"}, 32'(mario_h), mLive[0].h);
      checkOutput({tag, "_mario_v"}, 32'(mario_v), mLive[0].v);
      checkOutput({tag, "_barril_h"}, 32'(barril_h), mLive[1].h);
      checkOutput({tag, "_barril_v"}, 32'(barril_v), mLive[1].v);
      checkOutput({tag, "_dk_h"}, 32'(dk_h), mLive[2].h);
      checkOutput({tag, "_dk_v"}, 32'(dk_v), mLive[2].v);
      checkOutput({tag, "_display_barril"}, 32'(display_barril), mLive[1].vis);
   endtask

   task automatic checkSprites(input string tag);
      checkOutput({tag, "_sprite_m"}, 32'(sprite_m), expSprite(0));
      checkOutput({tag, "_sprite_dk"}, 32'(sprite_dk), expSprite(2));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      hcount = 10'($urandom_range(0, 639));
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] data);
      bit done;
      done     = 1'b0;
      wr_sel   = sel;
      wr_data  = data;
      wr_valid = 1'b1;
      for (int i = 0; i < 6 && !done; i++) begin
         if (wr_ready) begin
            modelWrite(sel, data);
            done = 1'b1;
         end
         step();
      end
      wr_valid = 1'b0;
      checkOutput("wr_accept", 32'(done), 1);
   endtask

   // Drives one vblank entry, optionally with a write on the edge cycle, then holds vcount.
   task automatic frameEdge(input int hold, input bit edgeWrite, input logic [1:0] sel, input logic [31:0] data);
      bit seen;
      int extra;
      seen   = 1'b0;
      extra  = 0;
      vcount = 10'd480;
      if (edgeWrite) begin
         checkOutput("edge_wr_ready", 32'(wr_ready), 1);
         wr_sel   = sel;
         wr_data  = data;
         wr_valid = 1'b1;
         modelWrite(sel, data);
      end
      step();
      wr_valid = 1'b0;
      checkOutput("commit_wr_ready", 32'(wr_ready), 0);
      for (int i = 0; i < 6 && !seen; i++) begin
         if (frame_tick) seen = 1'b1;
         else begin
            checkPositions("pre_commit");
            step();
         end
      end
      checkOutput("frame_tick_seen", 32'(seen), 1);
      modelCommit();
      checkPositions("commit");
      checkOutput("tick_wr_ready", 32'(wr_ready), 0);
      step();
      checkOutput("tick_width", 32'(frame_tick), 0);
      checkOutput("idle_wr_ready", 32'(wr_ready), 1);
      checkSprites("anim");
      for (int i = 0; i < hold; i++) begin
         step();
         if (frame_tick) extra++;
      end
      checkOutput("single_tick", 32'(extra), 0);
      vcount = 10'($urandom_range(0, 479));
      step();
   endtask

   initial begin
      logic [1:0]  rSel;
      logic [31:0] rData;
      int          nWrites;

      reset    = 1'b1;
      hcount   = '0;
      vcount   = '0;
      wr_valid = 1'b0;
      wr_sel   = '0;
      wr_data  = '0;
      modelReset();

      $display("[TB] reset defaults");
      step(); step(); step();
      checkOutput("reset_wr_ready", 32'(wr_ready), 0);
      checkOutput("reset_frame_tick", 32'(frame_tick), 0);
      reset = 1'b0;
      checkPositions("reset");
      checkSprites("reset");
      step();
      checkOutput("ready_after_reset", 32'(wr_ready), 1);

      $display("[TB] deferred mario write");
      vcount = 10'd100;
      step();
      applyStimulus(2'd0, mkWord(300, 400, 1, 0, 0));
      for (int i = 0; i < 4; i++) begin
         vcount = 10'(101 + i);
         step();
         checkPositions("hold");
      end
      frameEdge(2, 1'b0, 2'd0, '0);

      $display("[TB] barril clamp and hide");
      applyStimulus(2'd1, mkWord(1000, 700, 0, 0, 0));
      frameEdge(1, 1'b0, 2'd0, '0);

      $display("[TB] write on edge cycle with held follow-up");
      vcount = 10'd100;
      step();
      vcount = 10'd480;
      checkOutput("t4_ready_edge", 32'(wr_ready), 1);
      wr_valid = 1'b1;
      wr_sel   = 2'd2;
      wr_data  = mkWord(50, 300, 1, 0, 0);
      modelWrite(2'd2, wr_data);
      step();
      wr_sel  = 2'd0;
      wr_data = mkWord(77, 88, 1, 2, 1);
      checkOutput("t4_ready_commit", 32'(wr_ready), 0);
      step();
      checkOutput("t4_ready_anim", 32'(wr_ready), 0);
      checkOutput("t4_tick", 32'(frame_tick), 1);
      modelCommit();
      checkPositions("t4");
      step();
      checkOutput("t4_ready_idle", 32'(wr_ready), 1);
      modelWrite(2'd0, wr_data);
      step();
      wr_valid = 1'b0;
      checkSprites("t4");
      vcount = 10'd200;
      step();
      frameEdge(0, 1'b0, 2'd0, '0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 30; f++) begin
         nWrites = $urandom_range(0, 3);
         for (int w = 0; w < nWrites; w++) begin
            rSel  = 2'($urandom_range(0, 3));
            rData = $urandom;
            applyStimulus(rSel, rData);
         end
         rSel  = 2'($urandom_range(0, 3));
         rData = $urandom;
         frameEdge($urandom_range(0, 4), ($urandom_range(0, 2) == 0), rSel, rData);
      end

      $display("[TB] reset with pending writes");
      vcount = 10'd50;
      step();
      applyStimulus(2'd0, mkWord(10, 20, 1, 3, 1));
      applyStimulus(2'd1, mkWord(30, 40, 0, 0, 0));
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      modelReset();
      checkPositions("t6_reset");
      vcount = 10'd60;
      step();
      frameEdge(1, 1'b0, 2'd0, '0);

      $display("[TB] reset during commit");
      applyStimulus(2'd2, mkWord(5, 6, 1, 2, 1));
      vcount = 10'd480;
      step();
      reset  = 1'b1;
      step();
      reset  = 1'b0;
      vcount = 10'd10;
      modelReset();
      checkPositions("commit_reset");
      checkOutput("commit_reset_tick", 32'(frame_tick), 0);
      step();
      frameEdge(0, 1'b0, 2'd0, '0);

      $display("[TB] animation sequence");
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      modelReset();
      step();
      for (int f = 0; f < 16; f++) begin
         frameEdge(0, 1'b0, 2'd0, '0);
         if (f == 7) checkOutput("anim_frame8_sprite_m", 32'(sprite_m), 0);
         if (f == 15) checkOutput("anim_frame16_sprite_m", 32'(sprite_m), 1);
      end
      frameEdge(800, 1'b0, 2'd0, '0);
      checkSprites("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
